// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle short/long/double events plus a hold level.
// Thresholds are counted in milliseconds using a prescaler derived from the clock rate.
module button_event_decoder #(
    parameter int ClkRate = 10_000_000,
    parameter int LongMs  = 800,
    parameter int GapMs   = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db_level_i,
    output logic short_o,
    output logic long_o,
    output logic double_o,
    output logic hold_o
);

    localparam int PrescDiv = ClkRate / 1000;
    localparam int MaxMs    = (LongMs > GapMs) ? LongMs : GapMs;
    localparam int PW       = (PrescDiv > 1) ? $clog2(PrescDiv) : 1;
    localparam int MW       = (MaxMs > 0) ? $clog2(MaxMs + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PrescDiv - 1);
    localparam logic [MW-1:0] MS_MAX     = MW'(MaxMs);
    localparam logic [MW-1:0] LONG_MS    = MW'(LongMs);
    localparam logic [MW-1:0] GAP_MS     = MW'(GapMs);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_HOLD   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            lvl_r;
    logic [PW-1:0]   presc_r;
    logic [MW-1:0]   ms_r;
    logic            short_r;
    logic            long_r;
    logic            double_r;
    logic            hold_r;
    logic            press_s;
    logic            release_s;
    logic            short_s;
    logic            long_s;
    logic            double_s;

    assign press_s   = db_level_i & ~lvl_r;
    assign release_s = ~db_level_i & lvl_r;

    // Next-state and pulse decode; release beats the long threshold, press beats the gap timeout.
    always_comb begin
        state_s  = state_r;
        short_s  = 1'b0;
        long_s   = 1'b0;
        double_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_s = ST_PRESS1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (release_s) begin
                    state_s = ST_GAP;
                end else if (ms_r == LONG_MS) begin
                    state_s = ST_HOLD;
                    long_s  = 1'b1;
                end else begin
                    state_s = ST_PRESS1;
                end
            end
            ST_HOLD: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (press_s) begin
                    state_s  = ST_PRESS2;
                    double_s = 1'b1;
                end else if (ms_r == GAP_MS) begin
                    state_s = ST_IDLE;
                    short_s = 1'b1;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_PRESS2: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PRESS2;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, level history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            lvl_r    <= 1'b0;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            double_r <= 1'b0;
            hold_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            lvl_r    <= db_level_i;
            short_r  <= short_s;
            long_r   <= long_s;
            double_r <= double_s;
            hold_r   <= (state_s == ST_HOLD);
        end
    end

    // Millisecond time base; restarts on every state change so each state times from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            ms_r    <= '0;
        end else if (state_s != state_r) begin
            presc_r <= '0;
            ms_r    <= '0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
            if (ms_r != MS_MAX) begin
                ms_r <= ms_r + MW'(1);
            end else begin
                ms_r <= ms_r;
            end
        end else begin
            presc_r <= presc_r + PW'(1);
            ms_r    <= ms_r;
        end
    end

    assign short_o  = short_r;
    assign long_o   = long_r;
    assign double_o = double_r;
    assign hold_o   = hold_r;

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies button activity from an already-debounced level into single-cycle event pulses: short press, long press and double click. Sits directly downstream of the debouncer and consumes its debounced level output; it performs no synchronisation or debouncing of its own. Time thresholds are given in milliseconds and derived from the clock rate through an internal 1 ms prescaler.

## Interface
- ClkRate, 10_000_000: clock frequency in Hz. Must be a multiple of 1000 and at least 1000.
- LongMs, 800: hold time in ms that turns a press into a long press. Must be at least 1.
- GapMs, 250: maximum release-to-press gap in ms for a double click. Must be at least 1.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- db_level_i  input  1  debounced button level, 1 = pressed. Synchronous to clk.
- short_o  output  1  one-cycle pulse: a short single press completed.
- long_o  output  1  one-cycle pulse: the long-press threshold was reached.
- double_o  output  1  one-cycle pulse: a second press started within the gap.
- hold_o  output  1  level: high while a long press is still held.

## Operation
- Edge detect: lvl_q registers db_level_i. press = db_level_i & ~lvl_q; release = ~db_level_i & lvl_q.
- Time base: C = ClkRate/1000. The prescaler counts 0..C-1. ms_cnt increments when the prescaler wraps and saturates at max(LongMs, GapMs). Its width is $clog2(max+1). Both counters clear on every state transition.
- FSM states and transitions:
  - IDLE: on press, go to PRESS1.
  - PRESS1:
    - On release, go to GAP.
    - Otherwise, when ms_cnt == LongMs, go to HOLD and pulse long_o.
    - If release and the threshold occur in the same cycle, release wins and the FSM goes to GAP.
  - HOLD: hold_o = 1. On release, go to IDLE. No short_o is issued.
  - GAP:
    - On press, go to PRESS2 and pulse double_o.
    - Otherwise, when ms_cnt == GapMs, go to IDLE and pulse short_o.
    - If press and timeout occur in the same cycle, press wins (double click).
  - PRESS2: on release, go to IDLE. No long detection and no further pulses.
- All outputs are registered. At most one pulse output is high in any cycle. hold_o is high exactly while the state is HOLD.
- Reset values: state IDLE; lvl_q 0; counters 0; short_o, long_o, double_o and hold_o all 0.
- Reset mid-operation: every output drops to 0 immediately and asynchronously, and no pending event is reported. If the button is held when reset deasserts, the first cycle sees a press (because lvl_q = 0), and a new press sequence starts.

## Timing
- Edge E0 is the first rising edge that samples db_level_i = 1. At E0 the state enters PRESS1 and the counters clear.
- long_o is high in the cycle following edge E0 + LongMs·C + 1. It lasts exactly one cycle. hold_o rises together with long_o.
- Edge R is the edge that enters GAP.
  - short_o is high in the cycle following edge R + GapMs·C + 1, if no press occurs.
  - A press sampled at any edge up to and including R + GapMs·C + 1 yields double_o in the cycle after that edge.
- Latency from a detected edge to state change or pulse is 1 clock.
- Back-to-back sequences: a new press is accepted in the first cycle after returning to IDLE.

## Test plan
Use ClkRate = 10_000 (C = 10), LongMs = 8 and GapMs = 3 unless noted.
- Reset: hold rst_n = 0 with db_level_i toggling -> all outputs stay 0. Assert rst_n low during HOLD -> hold_o falls immediately, and no pulse follows.
- Short press: press for 20 cycles, then release -> exactly one short_o pulse, 31 edges after the release edge. No other pulses.
- Long press: press and hold for 200 cycles -> long_o pulses once, 81 edges after E0. hold_o stays high until the cycle after release. No short_o.
- Double click: press 20 cycles, release 15 cycles, press 20 cycles -> one double_o pulse the cycle after the second press edge. No short_o or long_o, even if the second press is held for 200 cycles.
- Gap boundaries: second press at exactly R + 31 -> double_o. Second press at R + 32 -> short_o at R + 31, then the new press starts a fresh sequence.
- Threshold collision: release sampled at exactly E0 + 81 -> FSM enters GAP with no long_o. Then, with no second press, short_o fires after the gap.
